// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-field widths for the write-through data cache.
package dcache_pkg;
    localparam int DEF_INDEX_W    = 6;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_WBUF_DEPTH = 4;

    function automatic int wo_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_w(input int index_w, input int line_words);
        return 30 - wo_w(line_words) - index_w;
    endfunction

    localparam int DEF_WO_W  = wo_w(DEF_LINE_WORDS);
    localparam int DEF_TAG_W = tag_w(DEF_INDEX_W, DEF_LINE_WORDS);

    typedef enum logic [2:0] {IDLE, DRAIN, RDREQ, FILL, RESP} state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wbuf_ent_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side request port and external memory bus port of the data cache.
interface dcache_cpu_if;
    logic        req_valid;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        data_cache_ready;
    logic [31:0] rdata;
    modport slave  (input req_valid, req_we, req_addr, req_wdata, output data_cache_ready, rdata);
    modport master (output req_valid, req_we, req_addr, req_wdata, input data_cache_ready, rdata);
endinterface

interface dcache_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: posted-write FIFO; pointers carry an extra wrap bit to tell full from empty.
module dcache_wbuf
    import dcache_pkg::*;
#(
    parameter int DEPTH = DEF_WBUF_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wbuf_ent_t i_din,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wbuf_ent_t o_head
);
    localparam int AW = $clog2(DEPTH);

    wbuf_ent_t  r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        w_do_pop, w_do_push;

    assign o_empty   = r_wp == r_rp;
    assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_head    = r_mem[r_rp[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // a push into a full buffer lands in the slot being popped this same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end

    always_ff @(posedge clk)
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking direct-mapped write-through, no-write-allocate data cache.
// Flop arrays give same-cycle hit data; stores post into dcache_wbuf and drain ahead of refills.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W    = DEF_INDEX_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
    input logic          clk,
    input logic          rst,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);
    localparam int WO    = wo_w(LINE_WORDS);
    localparam int TAG_W = tag_w(INDEX_W, LINE_WORDS);
    localparam int LINES = 1 << INDEX_W;
    localparam logic [WO-1:0] LAST = WO'(LINE_WORDS - 1);

    state_t             r_state, w_next;
    logic [31:0]        r_addr;
    logic [WO-1:0]      r_cnt;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES*LINE_WORDS];

    logic [INDEX_W-1:0] w_idx, w_ridx;
    logic [WO-1:0]      w_word, w_rword;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit, w_load, w_store, w_wr, w_pop, w_push, w_full, w_empty, w_beat, w_fill_last;
    wbuf_ent_t          w_ent, w_head;

    assign w_idx   = cpu.req_addr[WO+2 +: INDEX_W];
    assign w_word  = cpu.req_addr[2 +: WO];
    assign w_tag   = cpu.req_addr[31 -: TAG_W];
    assign w_ridx  = r_addr[WO+2 +: INDEX_W];
    assign w_rword = r_addr[2 +: WO];
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_load  = cpu.req_valid && (cpu.req_we == 4'b0000);
    assign w_store = cpu.req_valid && (cpu.req_we != 4'b0000);

    assign w_ent.addr  = cpu.req_addr[31:2];
    assign w_ent.wstrb = cpu.req_we << cpu.req_addr[1:0];
    assign w_ent.wdata = cpu.req_wdata << {cpu.req_addr[1:0], 3'b000};

    // writes only go out while no refill owns the bus, so reads never pass them
    assign w_wr        = !w_empty && (r_state == IDLE || r_state == DRAIN);
    assign w_pop       = w_wr && mem.mem_gnt;
    assign w_push      = (r_state == IDLE) && w_store && (!w_full || w_pop);
    assign w_beat      = (r_state == FILL) && mem.mem_rvalid;
    assign w_fill_last = w_beat && (r_cnt == LAST);

    dcache_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_din  (w_ent),
        .i_pop  (w_pop),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_head (w_head)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_load && !w_hit) w_next = w_empty ? RDREQ : DRAIN;
            DRAIN:   if (w_empty) w_next = RDREQ;
            RDREQ:   if (mem.mem_gnt) w_next = FILL;
            FILL:    if (w_fill_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu.data_cache_ready = (r_state == IDLE) ? (!cpu.req_valid || (w_load && w_hit) || w_push)
                                                 : (r_state == RESP) && cpu.req_valid;
        cpu.rdata     = (r_state == IDLE && w_load && w_hit) ? r_data[{w_idx, w_word}]
                      : (r_state == RESP && w_load)          ? r_data[{w_ridx, w_rword}] : '0;
        mem.mem_req   = w_wr || (r_state == RDREQ);
        mem.mem_we    = w_wr;
        mem.mem_addr  = w_wr ? {w_head.addr, 2'b00}
                      : (r_state == RDREQ) ? {r_addr[31:WO+2], {(WO+2){1'b0}}} : '0;
        mem.mem_wdata = w_wr ? w_head.wdata : '0;
        mem.mem_wstrb = w_wr ? w_head.wstrb : '0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_load && !w_hit) r_addr <= cpu.req_addr;
            // line is invalid from the first refill beat until the last one lands
            if (r_state == RDREQ && mem.mem_gnt) begin
                r_cnt           <= '0;
                r_valid[w_ridx] <= 1'b0;
            end
            if (w_beat) r_cnt <= r_cnt + 1'b1;
            if (w_fill_last) r_valid[w_ridx] <= 1'b1;
        end

    always_ff @(posedge clk) begin
        if (w_beat) r_data[{w_ridx, r_cnt}] <= mem.mem_rdata;
        if (w_fill_last) r_tag[w_ridx] <= r_addr[31 -: TAG_W];
        if (w_push && w_hit)
            for (int b = 0; b < 4; b++)
                if (w_ent.wstrb[b]) r_data[{w_idx, w_word}][8*b +: 8] <= w_ent.wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vectors against a small bus model with auto-grant and 4-beat refills.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_cpu_if cpu ();
    dcache_mem_if mem ();

    dcache_ctrl #(.INDEX_W(6), .LINE_WORDS(4), .WBUF_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .cpu(cpu),
        .mem(mem)
    );

    int          vecs = 0, errs = 0;
    bit          gnt_en = 1'b1;
    int          beats_left = 0;
    logic [31:0] rd_base = '0;
    logic [31:0] log_addr [$];
    bit          log_we [$];

    // backing memory: beat k of a line holds 0x11*(k+1), top byte from addr[17:10]
    function automatic logic [31:0] mem_word(input logic [31:0] base, input int k);
        return {base[17:10], 16'h0000, 8'((k + 1) * 17)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            mem.mem_rvalid = beats_left > 0;
            mem.mem_rdata  = (beats_left > 0) ? mem_word(rd_base, 4 - beats_left) : '0;
            if (beats_left > 0) beats_left--;
            mem.mem_gnt = gnt_en && mem.mem_req;
            if (mem.mem_gnt) begin
                log_addr.push_back(mem.mem_addr);
                log_we.push_back(mem.mem_we);
                if (!mem.mem_we) begin
                    rd_base    = mem.mem_addr;
                    beats_left = 4;
                end
            end
        end
    end

    task automatic req(input bit v, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu.req_valid = v;
        cpu.req_we    = we;
        cpu.req_addr  = a;
        cpu.req_wdata = d;
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) req(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic load_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req(1'b1, 4'h0, a, 32'h0);
        check({tag, "_rdy"}, cpu.data_cache_ready, 1);
        check({tag, "_data"}, cpu.rdata, exp);
    endtask

    task automatic store(input string tag, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] d, input bit exp_rdy);
        req(1'b1, we, a, d);
        check(tag, cpu.data_cache_ready, exp_rdy);
    endtask

    task automatic load_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int beats = 0;
        bit seen = 0, done = 0;
        req(1'b1, 4'h0, a, 32'h0);
        check({tag, "_rdy0"}, cpu.data_cache_ready, 0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #3;
            if (mem.mem_rvalid) beats++;
            if (mem.mem_gnt && !mem.mem_we) begin
                check({tag, "_raddr"}, mem.mem_addr, {a[31:4], 4'h0});
                beats = 0;
                seen  = 1;
            end
            if (cpu.data_cache_ready) done = 1;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_rd"}, 32'(seen), 1);
        check({tag, "_beats"}, beats, 4);
        check({tag, "_data"}, cpu.rdata, exp);
    endtask

    task automatic wait_drain();
        gnt_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (!mem.mem_req) break;
        end
        check("drain", mem.mem_req, 0);
    endtask

    initial begin
        cpu.req_valid = 1'b0;
        cpu.req_we    = '0;
        cpu.req_addr  = '0;
        cpu.req_wdata = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_ready", cpu.data_cache_ready, 1);
        check("rst_rdata", cpu.rdata, 0);
        check("rst_req", mem.mem_req, 0);
        check("rst_we", mem.mem_we, 0);
        check("rst_addr", mem.mem_addr, 0);
        check("rst_wdata", mem.mem_wdata, 0);
        check("rst_wstrb", mem.mem_wstrb, 0);
        @(negedge clk);
        rst = 1'b1;

        load_miss("cold100", 32'h100, 32'h11);
        load_hit("hit108", 32'h108, 32'h33);

        gnt_en = 1'b0;
        store("sb_rdy", 4'b0001, 32'h101, 32'hAB, 1);
        idle(1);
        check("sb_req", mem.mem_req, 1);
        check("sb_we", mem.mem_we, 1);
        check("sb_addr", mem.mem_addr, 32'h100);
        check("sb_wstrb", mem.mem_wstrb, 4'b0010);
        check("sb_wdata", mem.mem_wdata, 32'h0000AB00);
        load_hit("merge100", 32'h100, 32'h0000AB11);
        wait_drain();

        gnt_en = 1'b0;
        log_addr.delete();
        log_we.delete();
        for (int i = 0; i < 5; i++) store($sformatf("sw%0d", i), 4'hF, 32'h300 + 4 * i, i, i < 4);
        @(negedge clk);
        gnt_en = 1'b1;
        #3;
        check("full_pop_rdy", cpu.data_cache_ready, 1);
        check("full_pop_addr", mem.mem_addr, 32'h300);
        gnt_en = 1'b0;
        store("still_full", 4'hF, 32'h314, 32'h5, 0);
        idle(1);
        wait_drain();
        check("sw_log_n", log_addr.size(), 5);
        check("sw_log_last", log_addr[log_addr.size()-1], 32'h310);

        log_addr.delete();
        log_we.delete();
        gnt_en = 1'b0;
        store("st500", 4'hF, 32'h500, 32'h1, 1);
        store("st504", 4'hF, 32'h504, 32'h2, 1);
        gnt_en = 1'b1;
        load_miss("rd200", 32'h200, 32'h11);
        check("ord_n", log_addr.size(), 3);
        check("ord0_we", log_we[0], 1);
        check("ord0_addr", log_addr[0], 32'h500);
        check("ord1_we", log_we[1], 1);
        check("ord1_addr", log_addr[1], 32'h504);
        check("ord2_we", log_we[2], 0);
        check("ord2_addr", log_addr[2], 32'h200);

        load_miss("l000", 32'h000, 32'h11);
        load_miss("l400", 32'h400, 32'h01000011);
        load_miss("l000b", 32'h000, 32'h11);

        begin
            int n = 0;
            req(1'b1, 4'h0, 32'h600, 32'h0);
            for (int i = 0; i < 30 && n < 2; i++) begin
                @(negedge clk);
                #3;
                if (mem.mem_rvalid) n++;
            end
            check("rst_mid_beats", n, 2);
            @(negedge clk);
            rst = 1'b0;
            cpu.req_valid = 1'b0;
            #3;
            check("rst_mid_req", mem.mem_req, 0);
            check("rst_mid_ready", cpu.data_cache_ready, 1);
            check("rst_mid_rdata", cpu.rdata, 0);
            @(negedge clk);
            rst = 1'b1;
            idle(3);
            load_miss("refetch600", 32'h600, 32'h01000011);
        end

        idle(1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
